// File: rtl/coin_change_tx.sv
// Greedy change dispenser: splits a cent amount into Q/D/N/P and sends each coin as a serial line-coded frame.
// Optional per-coin tally outputs (q_cnt/d_cnt/n_cnt/p_cnt) are built when COIN_TALLY_EN is defined.
module coin_change_tx #(
    parameter int GAP_BITS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] amount,
    output logic       busy,
    output logic       serial_out,
    output logic       coin_sent,
    output logic [1:0] coin_type,
    output logic [7:0] remaining,
`ifdef COIN_TALLY_EN
    output logic [3:0] q_cnt,
    output logic [3:0] d_cnt,
    output logic [3:0] n_cnt,
    output logic [3:0] p_cnt,
`endif
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        SEND   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [1:0] COIN_P = 2'b00;
    localparam logic [1:0] COIN_N = 2'b01;
    localparam logic [1:0] COIN_D = 2'b10;
    localparam logic [1:0] COIN_Q = 2'b11;

    localparam int              GW       = $clog2(GAP_BITS);
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_BITS - 1);

    state_t        r_state;
    logic [3:0]    r_shift;
    logic [2:0]    r_bits_left;
    logic [1:0]    r_coin;
    logic [7:0]    r_coin_val;
    logic [GW-1:0] r_gap_cnt;
    logic [7:0]    r_remaining;
    logic          r_busy;
    logic          r_serial;
    logic          r_coin_sent;
    logic [1:0]    r_coin_type;
    logic          r_done;

    logic [1:0]    w_sel_type;
    logic [7:0]    w_sel_val;
    logic [4:0]    w_sel_frame;
    logic [2:0]    w_sel_len;
    logic          w_gap_end;
    logic          w_pick;
    logic          w_take_coin;
    logic          w_finish;

`ifdef COIN_TALLY_EN
    logic [3:0]    r_q_cnt;
    logic [3:0]    r_d_cnt;
    logic [3:0]    r_n_cnt;
    logic [3:0]    r_p_cnt;
`endif

    // Frames are stored LSB = first transmitted bit; every frame begins with a 0 start bit.
    always_comb begin
        w_sel_type  = COIN_P;
        w_sel_val   = 8'd1;
        w_sel_frame = 5'b00010;
        w_sel_len   = 3'd4;
        if (r_remaining >= 8'd25) begin
            w_sel_type  = COIN_Q;
            w_sel_val   = 8'd25;
            w_sel_frame = 5'b01010;
            w_sel_len   = 3'd5;
        end else if (r_remaining >= 8'd10) begin
            w_sel_type  = COIN_D;
            w_sel_val   = 8'd10;
            w_sel_frame = 5'b01110;
            w_sel_len   = 3'd5;
        end else if (r_remaining >= 8'd5) begin
            w_sel_type  = COIN_N;
            w_sel_val   = 8'd5;
            w_sel_frame = 5'b01000;
            w_sel_len   = 3'd5;
        end
    end

    // The last gap cycle doubles as the selection slot so frames run back to back.
    assign w_gap_end   = (r_state == GAP) && (r_gap_cnt == '0);
    assign w_pick      = (r_state == SELECT) || w_gap_end;
    assign w_take_coin = w_pick && (r_remaining != 8'd0);
    assign w_finish    = w_pick && (r_remaining == 8'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_shift     <= 4'd0;
            r_bits_left <= 3'd0;
            r_coin      <= COIN_P;
            r_coin_val  <= 8'd0;
            r_gap_cnt   <= '0;
            r_remaining <= 8'd0;
            r_busy      <= 1'b0;
            r_serial    <= 1'b1;
            r_coin_sent <= 1'b0;
            r_coin_type <= COIN_P;
            r_done      <= 1'b0;
`ifdef COIN_TALLY_EN
            r_q_cnt     <= 4'd0;
            r_d_cnt     <= 4'd0;
            r_n_cnt     <= 4'd0;
            r_p_cnt     <= 4'd0;
`endif
        end else begin
            r_coin_sent <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_serial <= 1'b1;
                    if (load) begin
                        r_remaining <= amount;
                        r_busy      <= 1'b1;
                        r_state     <= SELECT;
`ifdef COIN_TALLY_EN
                        r_q_cnt     <= 4'd0;
                        r_d_cnt     <= 4'd0;
                        r_n_cnt     <= 4'd0;
                        r_p_cnt     <= 4'd0;
`endif
                    end
                end
                SELECT: begin
                end
                SEND: begin
                    if (r_bits_left == 3'd0) begin
                        r_serial    <= 1'b1;
                        r_remaining <= r_remaining - r_coin_val;
                        r_coin_sent <= 1'b1;
                        r_coin_type <= r_coin;
                        r_gap_cnt   <= GAP_LAST;
                        r_state     <= GAP;
`ifdef COIN_TALLY_EN
                        case (r_coin)
                            COIN_Q:  r_q_cnt <= r_q_cnt + 4'd1;
                            COIN_D:  r_d_cnt <= r_d_cnt + 4'd1;
                            COIN_N:  r_n_cnt <= r_n_cnt + 4'd1;
                            default: r_p_cnt <= r_p_cnt + 4'd1;
                        endcase
`endif
                    end else begin
                        r_serial    <= r_shift[0];
                        r_shift     <= {1'b0, r_shift[3:1]};
                        r_bits_left <= r_bits_left - 3'd1;
                    end
                end
                GAP: begin
                    r_serial <= 1'b1;
                    if (!w_gap_end) begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_take_coin) begin
                r_serial    <= w_sel_frame[0];
                r_shift     <= w_sel_frame[4:1];
                r_bits_left <= w_sel_len - 3'd1;
                r_coin      <= w_sel_type;
                r_coin_val  <= w_sel_val;
                r_state     <= SEND;
            end

            if (w_finish) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= IDLE;
            end
        end
    end

    assign busy       = r_busy;
    assign serial_out = r_serial;
    assign coin_sent  = r_coin_sent;
    assign coin_type  = r_coin_type;
    assign remaining  = r_remaining;
    assign done       = r_done;

`ifdef COIN_TALLY_EN
    assign q_cnt = r_q_cnt;
    assign d_cnt = r_d_cnt;
    assign n_cnt = r_n_cnt;
    assign p_cnt = r_p_cnt;
`endif

endmodule

// File: doc/coin_change_tx.md
Name: coin_change_tx

Overview:
- Change dispenser and serial transmitter. Takes a change amount in cents and breaks it greedily into quarters, dimes, nickels and pennies.
- Emits each coin as a serial frame, using the same line codes the coin sensor decodes, so a dispensed coin stream can be looped back into the coin-sensor input.
- Sits beside the piggy bank: the purchase path loads the leftover credit, and this block drives the coin line.

Parameters:
- GAP_BITS, 5, number of idle-high bits sent after every frame; minimum legal value 5, so the receiver's 5-bit shift window refills with ones.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-low.
- load  input  1  start request; sampled on posedge only while busy=0.
- amount  input  8  change in cents (0..255); captured with load.
- busy  output  1  high from the load-accept edge until the done edge.
- serial_out  output  1  coin line; idle level 1; changes on posedge only, so the receiver samples it on negedge mid-bit.
- coin_sent  output  1  one-cycle strobe, one per coin, on completion of that coin's last frame bit.
- coin_type  output  2  type of the coin just sent; valid with coin_sent; 00 penny, 01 nickel, 10 dime, 11 quarter.
- remaining  output  8  cents still to dispense.
- done  output  1  one-cycle strobe when the dispense completes.

Behaviour:
- Reset is synchronous, active-low, on clock clk.
- Reset values: serial_out=1, busy=0, coin_sent=0, coin_type=00, remaining=0, done=0, state IDLE.
- Reset mid-operation abandons the frame in progress immediately. serial_out returns to 1 on that edge and no coin_sent or done pulse is issued.
- Frame bit order is first-transmitted first:
  - penny: 0,1,0,0 (4 bits)
  - nickel: 0,0,0,1,0 (5 bits)
  - dime: 0,1,1,1,0 (5 bits)
  - quarter: 0,1,0,1,0 (5 bits)
- States:
  - IDLE: serial_out=1. If load=1 at edge E0: remaining<=amount, busy<=1, go to SELECT.
  - SELECT: no dedicated output cycle. On the edge leaving SELECT, pick the coin greedily: quarter if remaining>=25, else dime if >=10, else nickel if >=5, else penny. Load the frame and drive its first bit. Go to SEND.
  - SEND: drive bit k of the frame on the k-th edge after SELECT. On the edge that ends the last bit:
    - serial_out<=1
    - remaining<=remaining-value
    - coin_sent<=1, coin_type set to the coin just sent
    - go to GAP.
  - GAP: hold serial_out=1 for exactly GAP_BITS cycles. Then go to SELECT if remaining!=0. Otherwise go to IDLE with busy<=0 and done<=1 on the same edge.
- Timing:
  - First frame bit is valid after edge E0+1.
  - Frame period is len+GAP_BITS cycles: len=4 for a penny, 5 for the others.
  - Consecutive frames are back-to-back with no extra idle cycle.
- Arithmetic: remaining is an unsigned 8-bit value. Greedy selection guarantees remaining never underflows, and no saturation is needed.
- Boundaries:
  - load while busy=1 is ignored, and amount is not re-sampled.
  - amount=0: busy is high for exactly one cycle, done pulses on the next edge, no frame is sent, and serial_out stays 1.
  - load held high continuously: a new dispense starts on the first edge with busy=0, i.e. the cycle after done.
  - reset has priority over load on the same edge.

Optional Feature:
- Macro COIN_TALLY_EN.
- When defined:
  - Adds outputs q_cnt, d_cnt, n_cnt, p_cnt, each 4 bits.
  - All four clear to 0 on the load-accept edge and on reset.
  - Each increments on its own coin_sent strobe.
  - Values hold after done until the next accepted load.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- amount=1 -> serial_out after E0: 0,1,0,0 then 1 for 5 cycles. coin_sent with coin_type=00 on the 4th bit edge. done 5 cycles later. remaining=0.
- amount=41 -> frame order quarter, dime, nickel, penny. remaining steps 16, 6, 1, 0. Total 10+10+10+9=39 cycles from first bit to done.
- amount=255 -> 10 quarters then 1 nickel. 11 coin_sent pulses, done after 110 cycles. With COIN_TALLY_EN: q_cnt=10, n_cnt=1, d_cnt=0, p_cnt=0.
- amount=30, then load with amount=99 pulsed mid-quarter -> second load ignored. Output is a quarter then a nickel only, with remaining ending at 0.
- amount=75, reset low during the 3rd bit of the first quarter -> next edge: serial_out=1, busy=0, remaining=0. No coin_sent or done afterwards.
- Loopback: serial_out wired through a register to the coin sensor, amount=16 -> sensor reports one dime, one nickel and one penny, and the piggy bank credit increases by 16.
